// File: rtl/logic_unit_arbiter_pkg.sv
// lu_arb_pkg: shared types and constants for logic_unit_arbiter.
//   state_t        - arbiter FSM states (IDLE, EVAL, RESP)
//   LU_ARB_*_DEF   - default requester count and operand width
//   lu_arb_id_w()  - width of a requester index for a given requester count
package lu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LU_ARB_N_REQ_DEF = 4;
  localparam int LU_ARB_WIDTH_DEF = 1;

  function automatic int lu_arb_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_eval.sv
// or3_eval_unit: single registered evaluation stage q = (a ^ b) | (a & b) | c.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, clears q to 0
//   en     - capture enable; q holds its value while en is low
//   a,b,c  - WIDTH-bit operands
//   q      - WIDTH-bit registered result
module or3_eval_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = (a ^ b) | (a & b) | c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one or3_eval_unit between N_REQ requesters.
// A request sampled in IDLE is granted for one cycle (EVAL), the shared unit
// captures the winner's latched operands, and the result is strobed in RESP
// tagged with the winner's index. One service every 3 cycles.
// Ports:
//   clk, reset          - clock and asynchronous active-low reset
//   req                 - level request per requester
//   a_in, b_in, c_in    - packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt                 - one-hot grant, high for one cycle
//   busy                - high while not IDLE
//   q_out, q_valid,q_id - result, one-cycle strobe, owning requester index
// Configuration macro LU_ARB_RR_EN:
//   defined   - round-robin search starting at a rotating pointer
//   undefined - fixed priority, lowest index wins, no pointer register
module logic_unit_arbiter
  import lu_arb_pkg::*;
#(
  parameter  int N_REQ = LU_ARB_N_REQ_DEF,
  parameter  int WIDTH = LU_ARB_WIDTH_DEF,
  localparam int ID_W  = lu_arb_id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  input  logic [N_REQ*WIDTH-1:0] c_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       q_out,
  output logic                   q_valid,
  output logic [ID_W-1:0]        q_id
);

  state_t           state_d, state_q;
  logic [N_REQ-1:0] gnt_d, gnt_q;
  logic [ID_W-1:0]  win_d, win_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, c_d, c_q;
  logic [ID_W-1:0]  ptr;

  // Per-requester operand views
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] c_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
    assign c_arr[gi] = c_in[gi*WIDTH +: WIDTH];
  end

`ifdef LU_ARB_RR_EN
  logic [ID_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) begin
      ptr_d = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Wrap-around search as two passes: the lowest requester at or above the
  // pointer wins; if none, the lowest requester overall (the wrapped part).
  logic            any_req, hi_found;
  logic [ID_W-1:0] hi_idx, lo_idx, sel_idx;

  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        lo_idx  = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = sel_idx;
          gnt_d   = N_REQ'(1) << sel_idx;
          a_d     = a_arr[sel_idx];
          b_d     = b_arr[sel_idx];
          c_d     = c_arr[sel_idx];
          state_d = EVAL;
        end
      end
      EVAL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  or3_eval_unit #(
    .WIDTH (WIDTH)
  ) u_eval (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == EVAL),
    .a     (a_q),
    .b     (b_q),
    .c     (c_q),
    .q     (q_out)
  );

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign q_valid = (state_q == RESP);
  assign q_id    = win_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N*W-1:0] c_in = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   q_out;
  logic           q_valid;
  logic [1:0]     q_id;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
    .gnt     (gnt),
    .busy    (busy),
    .q_out   (q_out),
    .q_valid (q_valid),
    .q_id    (q_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;   // model search start

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N*W-1:0] c;
    logic [N-1:0]   eg;
    logic [W-1:0]   eq;
    int             eid;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner: first set request at or after p, wrapping past N-1.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_q(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                         input logic [N*W-1:0] c, input int i);
    return a[i*W +: W] | b[i*W +: W] | c[i*W +: W];
  endfunction

  task automatic advance_ptr(input int winner);
`ifdef LU_ARB_RR_EN
    ptr_m = (winner + 1) % N;
`else
    ptr_m = 0;
`endif
  endtask

  // Entered just after a negedge with the DUT idle.
  task automatic txn(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] a,
                     input logic [N*W-1:0] b, input logic [N*W-1:0] c,
                     input logic [N-1:0] eg, input logic [W-1:0] eq, input int eid);
    req = r; a_in = a; b_in = b; c_in = c;
    @(negedge clk);
    chk({tag, " gnt"}, gnt, eg);
    chk({tag, " busy"}, busy, (eg != 0));
    chk({tag, " qv_e0"}, q_valid, 0);
    req = '0;
    a_in = ~a; b_in = ~b; c_in = ~c;   // operands must already be latched
    if (eg == '0) begin
      $display("txn %s req=%b no grant", tag, r);
      return;
    end
    @(negedge clk);
    chk({tag, " gnt_off"}, gnt, 0);
    chk({tag, " q_valid"}, q_valid, 1);
    chk({tag, " q_id"}, q_id, eid);
    chk({tag, " q_out"}, q_out, eq);
    @(negedge clk);
    chk({tag, " qv_off"}, q_valid, 0);
    chk({tag, " busy_off"}, busy, 0);
    chk({tag, " q_hold"}, q_out, eq);
    advance_ptr(eid);
    $display("txn %s req=%b gnt=%b q=%h id=%0d", tag, r, eg, eq, eid);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rst_gnt"}, gnt, 0);
    chk({tag, " rst_busy"}, busy, 0);
    chk({tag, " rst_qv"}, q_valid, 0);
    chk({tag, " rst_q"}, q_out, 0);
    chk({tag, " rst_id"}, q_id, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    $display("txn %s reset", tag);
  endtask

  initial begin
    int w;
    int exp_w;
    logic [N-1:0]   r;
    logic [N*W-1:0] ra, rb, rc;

    tbl[0] = '{4'b0010, 16'h0010, 16'h0010, 16'h0000, 4'b0010, 4'h1, 1};
    tbl[1] = '{4'b0001, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 4'h0, 0};
    tbl[2] = '{4'b0001, 16'h000A, 16'h0000, 16'h0001, 4'b0001, 4'hB, 0};
    tbl[3] = '{4'b1000, 16'h5ABC, 16'h2111, 16'h0FFF, 4'b1000, 4'h7, 3};
    tbl[4] = '{4'b0100, 16'hF3F0, 16'h0A5F, 16'h1000, 4'b0100, 4'hB, 2};
    tbl[5] = '{4'b0010, 16'h00C0, 16'h0030, 16'hFF0F, 4'b0010, 4'hF, 1};

    #2 reset = 1'b0;
    #1 check_reset_outputs("init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed single-request vectors
    for (int i = 0; i < 6; i++) begin
      txn($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].c,
          tbl[i].eg, tbl[i].eq, tbl[i].eid);
    end

    // Contention: all requesters held high, 5 services 3 cycles apart
    do_reset("pre_cont");
    req = 4'b1111; a_in = 16'h1234; b_in = 16'h0000; c_in = 16'h0000;
    for (int g = 0; g < 5; g++) begin
`ifdef LU_ARB_RR_EN
      exp_w = g % N;
`else
      exp_w = 0;
`endif
      @(negedge clk);
      chk($sformatf("cont%0d gnt", g), gnt, 4'b0001 << exp_w);
      @(negedge clk);
      chk($sformatf("cont%0d q_valid", g), q_valid, 1);
      chk($sformatf("cont%0d q_id", g), q_id, exp_w);
      chk($sformatf("cont%0d q_out", g), q_out, ref_q(a_in, b_in, c_in, exp_w));
      @(negedge clk);
      chk($sformatf("cont%0d busy_off", g), busy, 0);
      advance_ptr(exp_w);
      $display("txn cont%0d gnt=%b", g, 4'b0001 << exp_w);
    end
    req = '0;

    // Wrap: grant requester 3, then 1001 must go to requester 0
    txn("wrap_a", 4'b1000, 16'h3000, 16'h0000, 16'h0000, 4'b1000, 4'h3, 3);
    txn("wrap_b", 4'b1001, 16'h0005, 16'h0000, 16'h0000, 4'b0001, 4'h5, 0);

    // Abort: move the pointer past 1, then reset during EVAL of requester 2
    do_reset("pre_abort");
    txn("abort_pre", 4'b0010, 16'h0020, 16'h0000, 16'h0000, 4'b0010, 4'h2, 1);
    req = 4'b0100; a_in = 16'h0700; b_in = '0; c_in = '0;
    @(negedge clk);
    chk("abort gnt", gnt, 4'b0100);
    req = '0;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort no_qv%0d", k), q_valid, 0);
    end
    $display("txn abort reset during EVAL");
    txn("abort_post", 4'b0110, 16'h0090, 16'h0000, 16'h0000, 4'b0010, 4'h9, 1);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      r  = N'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      w  = pick(r, ptr_m);
      if (w < 0) begin
        txn($sformatf("rnd%0d", i), r, ra, rb, rc, '0, '0, 0);
      end else begin
        txn($sformatf("rnd%0d", i), r, ra, rb, rc, 4'b0001 << w, ref_q(ra, rb, rc, w), w);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one registered logic-evaluation unit, computing q = (a ^ b) | (a & b) | c bitwise, between N_REQ requesters. Each requester presents operands with a request. The arbiter grants one requester at a time and drives the shared unit. It then returns the registered result tagged with the requester's index. It sits between the requesting control blocks and the single evaluation flop stage.

## Interface
- N_REQ, default 4: number of requesters, at least 2.
- WIDTH, default 1: operand and result width in bits.
- ID_W, derived as $clog2(N_REQ): width of the requester index.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, N_REQ: request per requester, level, held until granted.
- a_in, input, N_REQ*WIDTH: operand A. Requester i occupies slice [i*WIDTH +: WIDTH].
- b_in, input, N_REQ*WIDTH: operand B, same slicing.
- c_in, input, N_REQ*WIDTH: operand C, same slicing.
- gnt, output, N_REQ: one-hot grant, asserted for exactly one cycle.
- busy, output, 1: high while state != IDLE.
- q_out, output, WIDTH: result.
- q_valid, output, 1: one-cycle result strobe.
- q_id, output, ID_W: index of the requester that owns q_out.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If req != 0, select a winner and latch its a/b/c slices.
  - Register gnt = onehot(winner) and go to EVAL.
  - Otherwise stay in IDLE.
- EVAL:
  - Shared unit captures (a ^ b) | (a & b) | c from the latched operands.
  - gnt returns to 0. Go to RESP.
- RESP:
  - q_valid = 1, q_id = winner, q_out = unit output.
  - Round-robin pointer <= (winner + 1) mod N_REQ. Go to IDLE.
- Winner selection: the first asserted req at or after the pointer, searching upward with wrap from N_REQ-1 to 0.
- Requests outside IDLE are not sampled. A requester sees gnt and must drop or change req in the following cycle.
- A req withdrawn before being sampled in IDLE has no effect.
- q_out holds its last value after q_valid falls.
- Arithmetic is purely bitwise per WIDTH bit. There is no carry or extension.

## Timing
- Reset (reset = 0, async): state = IDLE, gnt = 0, busy = 0, q_valid = 0, q_out = 0, q_id = 0, pointer = 0, operand latches = 0.
- Reset is released synchronously by the user. The first request is sampled on the first rising edge with reset = 1.
- Edge E0 samples req in IDLE. From E0 to E1: gnt and busy are high. From E1 to E2: q_valid is high. After E2 the FSM is in IDLE, busy is low, and a new request may be sampled at E3.
- Throughput: one grant per 3 cycles. Continuous req from all requesters gives a 3-cycle service rotation.
- Simultaneous requests: exactly one gnt bit is set. The remaining requests stay pending.
- Reset mid-EVAL or mid-RESP: the operation is aborted, no q_valid is produced, and the pointer returns to 0.

## Configuration
- Macro LU_ARB_RR_EN.
- Defined: round-robin arbitration with a rotating pointer, as described above.
- Undefined: fixed priority, lowest index wins. The pointer register is removed and the selection always starts at 0.

## Structure
- Package lu_arb_pkg contains:
  - State enum typedef (IDLE, EVAL, RESP).
  - Default N_REQ and WIDTH constants.
  - A function for the ID width.
- Sub-module or3_eval_unit:
  - Ports: clk, reset (async active-low), en, a, b, c, and q (WIDTH bits).
  - When en = 1 it registers (a ^ b) | (a & b) | c. It resets to 0.
  - The arbiter drives en during EVAL.

## Test plan
- Reset check: assert reset = 0 mid-stream. All outputs must be 0 immediately, without waiting for a clock edge.
- Single request: req = 0010, requester 1 has a = 1, b = 1, c = 0. Expect gnt = 0010 for one cycle after E0, then q_valid = 1 with q_out = 1 and q_id = 1 one cycle later.
- Zero operands: req = 0001 with a = b = c = 0. Expect q_out = 0 and q_id = 0. With WIDTH = 4, a = 1010, b = 0000, c = 0001, expect q_out = 1011.
- Contention:
  - Setup: req = 1111 held continuously.
  - With LU_ARB_RR_EN defined, grants must run 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
  - With LU_ARB_RR_EN undefined, every grant must be 0001.
- Wrap: after granting requester 3, present req = 1001. The next grant must be 0001.
- Abort: pulse reset low during EVAL for requester 2. Expect no q_valid. Then present req = 0110; the next grant must be 0010 because the pointer was reset to 0.
